// File: rtl/fifo_umbrales.sv
`default_nettype none
// ============================================================================
// Module      : fifo_umbrales
// Description : Synchronous FIFO with programmable almost-full/almost-empty
//               thresholds and sticky overflow/underflow flags.
// Revision    : 1.0
// ============================================================================
module fifo_umbrales #(
    parameter int DATA_WIDTH = 6,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enb,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    input  logic                  cfg_we,
    input  logic [ADDR_WIDTH:0]   cfg_alto,
    input  logic [ADDR_WIDTH:0]   cfg_bajo,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  overflow,
    output logic                  underflow,
    output logic [ADDR_WIDTH:0]   count
);

    localparam logic [ADDR_WIDTH:0] c_depth = {1'b1, {ADDR_WIDTH{1'b0}}};

    logic [DATA_WIDTH-1:0] mem_q [0:(2**ADDR_WIDTH)-1];

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic [ADDR_WIDTH:0]   alto_q, alto_d;
    logic [ADDR_WIDTH:0]   bajo_q, bajo_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                  valid_q, valid_d;
    logic                  ovf_q, ovf_d;
    logic                  udf_q, udf_d;
    logic                  push_ok;
    logic                  pop_ok;

    assign full         = (count_q == c_depth);
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= alto_q);
    assign almost_empty = (count_q != '0) && (count_q <= bajo_q);
    assign count        = count_q;
    assign data_out     = data_out_q;
    assign valid_out    = valid_q;
    assign overflow     = ovf_q;
    assign underflow    = udf_q;

    // A full FIFO still accepts a push when a pop frees a slot in the same cycle.
    assign push_ok = enb && wr_en && (!full || (rd_en && !empty));
    assign pop_ok  = enb && rd_en && !empty;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        alto_d     = alto_q;
        bajo_d     = bajo_q;
        data_out_d = data_out_q;
        valid_d    = 1'b0;
        ovf_d      = ovf_q;
        udf_d      = udf_q;

        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d   = rd_ptr_q + 1'b1;
            data_out_d = mem_q[rd_ptr_q];
            valid_d    = 1'b1;
        end

        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        if (enb && wr_en && !push_ok) begin
            ovf_d = 1'b1;
        end
        if (enb && rd_en && empty) begin
            udf_d = 1'b1;
        end

        // Both thresholds are validated against the values held before this load.
        if (enb && cfg_we) begin
            if ((cfg_alto != '0) && (cfg_alto <= c_depth)) begin
                alto_d = cfg_alto;
            end
            if (cfg_bajo < alto_q) begin
                bajo_d = cfg_bajo;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            alto_q     <= c_depth - 1'b1;
            bajo_q     <= (ADDR_WIDTH+1)'(1);
            data_out_q <= '0;
            valid_q    <= 1'b0;
            ovf_q      <= 1'b0;
            udf_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            alto_q     <= alto_d;
            bajo_q     <= bajo_d;
            data_out_q <= data_out_d;
            valid_q    <= valid_d;
            ovf_q      <= ovf_d;
            udf_q      <= udf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fifo_umbrales.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_umbrales
// Description : Scoreboard testbench for fifo_umbrales (8-deep, 6-bit).
// Revision    : 1.0
// ============================================================================
module tb_fifo_umbrales;

    logic       clk;
    logic       rst;
    logic       enb;
    logic       wr_en;
    logic [5:0] data_in;
    logic       rd_en;
    logic [5:0] data_out;
    logic       valid_out;
    logic       cfg_we;
    logic [3:0] cfg_alto;
    logic [3:0] cfg_bajo;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic       overflow;
    logic       underflow;
    logic [3:0] count;

    fifo_umbrales #(.DATA_WIDTH(6), .ADDR_WIDTH(3)) dut (
        .clk(clk), .rst(rst), .enb(enb), .wr_en(wr_en), .data_in(data_in),
        .rd_en(rd_en), .data_out(data_out), .valid_out(valid_out),
        .cfg_we(cfg_we), .cfg_alto(cfg_alto), .cfg_bajo(cfg_bajo),
        .full(full), .empty(empty), .almost_full(almost_full),
        .almost_empty(almost_empty), .overflow(overflow),
        .underflow(underflow), .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // {full, empty, almost_full, almost_empty, overflow, underflow, valid_out, count}
    logic [10:0] st;
    assign st = {full, empty, almost_full, almost_empty, overflow, underflow, valid_out, count};

    logic [5:0] exp_q[$];
    logic [5:0] sb_exp;
    int         mdl_cnt;
    logic [3:0] mdl_alto;
    logic [3:0] mdl_bajo;
    logic       mdl_ovf;
    logic       mdl_udf;
    logic       mdl_valid;

    function automatic logic [10:0] exp_status();
        logic [3:0] c;
        c = 4'(mdl_cnt);
        return {c == 4'd8, c == 4'd0, c >= mdl_alto, (c != 4'd0) && (c <= mdl_bajo),
                mdl_ovf, mdl_udf, mdl_valid, c};
    endfunction

    task automatic model_reset();
        mdl_cnt   = 0;
        mdl_alto  = 4'd7;
        mdl_bajo  = 4'd1;
        mdl_ovf   = 1'b0;
        mdl_udf   = 1'b0;
        mdl_valid = 1'b0;
        exp_q.delete();
    endtask

    // Applies one cycle of stimulus and advances the reference model.
    task automatic drive(input logic w, input logic [5:0] d, input logic r,
                         input logic cw, input logic [3:0] ca, input logic [3:0] cb);
        logic full_m, empty_m, psh, pp;
        full_m   = (mdl_cnt == 8);
        empty_m  = (mdl_cnt == 0);
        wr_en    = w;
        data_in  = d;
        rd_en    = r;
        cfg_we   = cw;
        cfg_alto = ca;
        cfg_bajo = cb;
        psh = enb && w && (!full_m || (r && !empty_m));
        pp  = enb && r && !empty_m;
        if (enb && w && !psh) mdl_ovf = 1'b1;
        if (enb && r && empty_m) mdl_udf = 1'b1;
        if (enb && cw) begin
            if (cb < mdl_alto) mdl_bajo = cb;
            if (ca >= 4'd1 && ca <= 4'd8) mdl_alto = ca;
        end
        if (psh) exp_q.push_back(d);
        mdl_cnt   = mdl_cnt + int'(psh) - int'(pp);
        mdl_valid = pp;
        @(posedge clk);
        #1;
        wr_en  = 1'b0;
        rd_en  = 1'b0;
        cfg_we = 1'b0;
    endtask

    task automatic push(input logic [5:0] d);  drive(1'b1, d, 1'b0, 1'b0, 4'd0, 4'd0); endtask
    task automatic pop();                      drive(1'b0, 6'd0, 1'b1, 1'b0, 4'd0, 4'd0); endtask
    task automatic both(input logic [5:0] d);  drive(1'b1, d, 1'b1, 1'b0, 4'd0, 4'd0); endtask
    task automatic idle();                     drive(1'b0, 6'd0, 1'b0, 1'b0, 4'd0, 4'd0); endtask
    task automatic cfg(input logic [3:0] a, input logic [3:0] b); drive(1'b0, 6'd0, 1'b0, 1'b1, a, b); endtask

    task automatic do_reset();
        #2 rst = 1'b0;
        model_reset();
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Consumer side of the scoreboard: every popped word is checked in order.
    always @(negedge clk) begin
        if (rst === 1'b1 && valid_out === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL sb_data: valid_out with no word expected, data_out=%h", data_out);
            end else begin
                sb_exp = exp_q.pop_front();
                if (data_out !== sb_exp) begin
                    n_errors++;
                    $display("FAIL sb_data: data_out=%h expected %h", data_out, sb_exp);
                end
            end
        end
    end

    task automatic test_reset();
        rst = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (st !== 11'b010_0000_0000) begin
            n_errors++;
            $display("FAIL reset_hold: status=%b expected %b", st, 11'b010_0000_0000);
        end
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (st !== 11'b010_0000_0000) begin
            n_errors++;
            $display("FAIL reset_release: status=%b expected %b", st, 11'b010_0000_0000);
        end
    endtask

    task automatic test_fill_overflow();
        for (int i = 1; i <= 9; i++) begin
            push(6'(i));
            n_checks++;
            if (st !== exp_status()) begin
                n_errors++;
                $display("FAIL fill_status[%0d]: status=%b expected %b", i, st, exp_status());
            end
            if (i == 7) begin
                n_checks++;
                if ({almost_full, full} !== 2'b10) begin
                    n_errors++;
                    $display("FAIL fill_af7: {af,full}=%b expected 10", {almost_full, full});
                end
            end
            if (i == 9) begin
                n_checks++;
                if ({full, overflow, count} !== {1'b1, 1'b1, 4'd8}) begin
                    n_errors++;
                    $display("FAIL fill_ovf9: {full,ovf,count}=%b expected 118", {full, overflow, count});
                end
            end
        end
        for (int i = 1; i <= 8; i++) begin
            pop();
            n_checks++;
            if (st !== exp_status()) begin
                n_errors++;
                $display("FAIL drain_status[%0d]: status=%b expected %b", i, st, exp_status());
            end
        end
        idle();
        n_checks++;
        if (empty !== 1'b1 || exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL drain_end: empty=%b pending=%0d expected empty=1 pending=0", empty, exp_q.size());
        end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 5; i++) push(6'(8'h10 + i));
        for (int i = 0; i < 3; i++) pop();
        for (int i = 0; i < 10; i++) begin
            both(6'(8'h20 + i));
            n_checks++;
            if (count !== 4'd2 || st !== exp_status()) begin
                n_errors++;
                $display("FAIL wrap_simul[%0d]: count=%0d status=%b expected count=2 status=%b",
                         i, count, st, exp_status());
            end
        end
        for (int i = 0; i < 6; i++) push(6'(8'h30 + i));
        n_checks++;
        if ({full, count} !== {1'b1, 4'd8}) begin
            n_errors++;
            $display("FAIL wrap_full: {full,count}=%b expected 11000", {full, count});
        end
        both(6'h3F);
        n_checks++;
        if ({full, overflow, count} !== {1'b1, 1'b0, 4'd8} || st !== exp_status()) begin
            n_errors++;
            $display("FAIL full_simul: status=%b expected %b", st, exp_status());
        end
        for (int i = 0; i < 8; i++) pop();
        idle();
        n_checks++;
        if (empty !== 1'b1 || exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL wrap_drain: empty=%b pending=%0d expected empty=1 pending=0", empty, exp_q.size());
        end
    endtask

    task automatic test_underflow();
        do_reset();
        both(6'h2A);
        n_checks++;
        if ({count, valid_out, underflow} !== {4'd1, 1'b0, 1'b1}) begin
            n_errors++;
            $display("FAIL empty_simul: {count,valid,udf}=%b expected 000101", {count, valid_out, underflow});
        end
        pop();
        n_checks++;
        if (st !== exp_status()) begin
            n_errors++;
            $display("FAIL udf_pop: status=%b expected %b", st, exp_status());
        end
        idle();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL udf_drain: pending=%0d expected 0", exp_q.size());
        end
    endtask

    task automatic test_thresholds();
        do_reset();
        cfg(4'd4, 4'd2);
        for (int k = 1; k <= 4; k++) begin
            push(6'(8'h08 + k));
            n_checks++;
            if (almost_empty !== (k <= 2) || almost_full !== (k >= 4) || st !== exp_status()) begin
                n_errors++;
                $display("FAIL thr_load[%0d]: ae=%b af=%b status=%b expected status %b",
                         k, almost_empty, almost_full, st, exp_status());
            end
        end
        pop();
        cfg(4'd0, 4'd2);
        n_checks++;
        if (almost_full !== 1'b0 || st !== exp_status()) begin
            n_errors++;
            $display("FAIL thr_alto0: af=%b at count=%0d expected 0", almost_full, count);
        end
        push(6'h0D);
        cfg(4'd9, 4'd2);
        n_checks++;
        if (almost_full !== 1'b1 || st !== exp_status()) begin
            n_errors++;
            $display("FAIL thr_alto9: af=%b at count=%0d expected 1", almost_full, count);
        end
        pop();
        cfg(4'd0, 4'd5);
        n_checks++;
        if (almost_empty !== 1'b0 || st !== exp_status()) begin
            n_errors++;
            $display("FAIL thr_bajo5: ae=%b at count=%0d expected 0", almost_empty, count);
        end
        for (int i = 0; i < 3; i++) begin
            pop();
            n_checks++;
            if (st !== exp_status()) begin
                n_errors++;
                $display("FAIL thr_drain[%0d]: status=%b expected %b", i, st, exp_status());
            end
        end
        idle();
    endtask

    task automatic test_enb_async();
        logic [10:0] held;
        do_reset();
        for (int i = 1; i <= 5; i++) push(6'(8'h40 + i));
        held = st;
        enb  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 6'h3F, i[0], 1'b1, 4'd2, 4'd1);
            n_checks++;
            if (st !== held || st !== exp_status()) begin
                n_errors++;
                $display("FAIL enb_hold[%0d]: status=%b expected %b", i, st, held);
            end
        end
        enb = 1'b1;
        pop();
        n_checks++;
        if (st !== exp_status()) begin
            n_errors++;
            $display("FAIL enb_resume: status=%b expected %b", st, exp_status());
        end
        idle();
        push(6'h15);
        n_checks++;
        if (count !== 4'd5) begin
            n_errors++;
            $display("FAIL async_pre: count=%0d expected 5", count);
        end
        #3 rst = 1'b0;
        #1;
        n_checks++;
        if (count !== 4'd0 || empty !== 1'b1) begin
            n_errors++;
            $display("FAIL async_reset: count=%0d empty=%b expected count=0 empty=1", count, empty);
        end
        model_reset();
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (st !== exp_status()) begin
            n_errors++;
            $display("FAIL async_after: status=%b expected %b", st, exp_status());
        end
    endtask

    initial begin
        rst      = 1'b0;
        enb      = 1'b1;
        wr_en    = 1'b0;
        rd_en    = 1'b0;
        data_in  = 6'd0;
        cfg_we   = 1'b0;
        cfg_alto = 4'd0;
        cfg_bajo = 4'd0;
        test_reset();
        test_fill_overflow();
        test_wrap();
        test_underflow();
        test_thresholds();
        test_enb_async();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/fifo_umbrales.md
Name: fifo_umbrales

Overview:
- Parameterised synchronous FIFO with programmable almost-full/almost-empty thresholds ("umbrales").
- Five instances sit directly upstream of the flow-control FSM; each drives one bit of the FSM's full/almost_full/almost_empty/empty buses.
- Thresholds are loaded through a config port, which system control drives only while the FSM is in INIT.

Parameters:
- DATA_WIDTH, 6, width of each stored word.
- ADDR_WIDTH, 3, pointer width; DEPTH = 2**ADDR_WIDTH (8 by default).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous and active-low (0 = reset).
- enb  input  1  global enable; when 0, requests are ignored and all state holds.
- wr_en  input  1  push request.
- data_in  input  DATA_WIDTH  push data.
- rd_en  input  1  pop request.
- data_out  output  DATA_WIDTH  registered pop data.
- valid_out  output  1  data_out holds a word popped on the previous edge.
- cfg_we  input  1  threshold load strobe.
- cfg_alto  input  ADDR_WIDTH+1  almost-full threshold to load.
- cfg_bajo  input  ADDR_WIDTH+1  almost-empty threshold to load.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- almost_full  output  1  count >= umbral_alto.
- almost_empty  output  1  count != 0 and count <= umbral_bajo.
- overflow  output  1  sticky: a push was attempted while full and was not accepted.
- underflow  output  1  sticky: a pop was attempted while empty.
- count  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH.

Behaviour:
- Reset (rst=0, asynchronous):
  - Pointers = 0, count = 0.
  - data_out = 0, valid_out = 0.
  - overflow = 0, underflow = 0.
  - umbral_alto = DEPTH-1, umbral_bajo = 1.
  - Memory contents undefined.
  - Reset asserted mid-operation discards all data immediately, without waiting for a clock edge.
- Status flags:
  - full, empty, almost_full and almost_empty are combinational decodes of the registered count and threshold registers.
  - They therefore change in the same cycle that count updates: zero added latency after the edge.
- Acceptance (evaluated only when enb=1):
  - Push is accepted if wr_en and (not full, or rd_en and not empty).
  - Pop is accepted if rd_en and not empty.
- Accepted push: mem[wr_ptr] <= data_in; wr_ptr increments, wrapping DEPTH-1 -> 0.
- Accepted pop:
  - data_out <= mem[rd_ptr]; valid_out <= 1; rd_ptr increments with wrap.
  - Read latency is 1 cycle.
  - With no accepted pop, valid_out <= 0 and data_out holds its last value.
- Count update:
  - Push only: +1.
  - Pop only: -1.
  - Both, or neither: unchanged.
- Boundary cases:
  - Full with simultaneous rd_en+wr_en: both are accepted and count stays DEPTH.
  - Empty with simultaneous rd_en+wr_en: push accepted, pop rejected (no fall-through), underflow set, count becomes 1.
  - Push rejected while full: data dropped, overflow set. overflow stays set until reset and drives the downstream FSM into its ERROR state.
  - Pop while empty: underflow set (sticky until reset), valid_out = 0.
- enb = 0:
  - No pointer, count, memory or sticky-flag change.
  - valid_out <= 0.
  - cfg_we is also ignored.
- Threshold load (cfg_we=1, enb=1) takes effect on the next edge. Each threshold is checked independently:
  - umbral_alto loads only if 1 <= cfg_alto <= DEPTH; otherwise it keeps its previous value.
  - umbral_bajo loads only if cfg_bajo < umbral_alto (compared against the pre-update umbral_alto); otherwise it keeps its previous value.
  - Loading a threshold does not disturb the data path. Flags re-evaluate against the new threshold in the cycle after the load.

Test Plan:
- Reset and defaults:
  - Stimulus: rst=0, then release; no requests.
  - Required: empty=1, full=0, almost_full=0, almost_empty=0, count=0, valid_out=0.
  - Thresholds read back via flags: 7 pushes -> almost_full=1 at count=7; 8th push -> full=1.
- Fill/overflow:
  - Stimulus: 9 consecutive pushes of 0x01..0x09.
  - Required: full=1 after the 8th; 9th dropped with overflow=1.
  - Then 8 pops: data_out sequence 0x01..0x08, each 1 cycle after rd_en; empty=1 at the end.
- Wrap and simultaneous:
  - Stimulus: push 5, pop 3, then 10 cycles of rd_en+wr_en.
  - Required: count stays 2 throughout; data order preserved across pointer wrap.
  - Next, fill to full (6 more pushes) and assert rd_en+wr_en -> count=8, full=1, overflow=0.
- Empty underflow:
  - Stimulus: empty FIFO, rd_en+wr_en with data 0x2A.
  - Required: count=1, valid_out=0, underflow=1; next pop returns 0x2A.
- Threshold config:
  - Stimulus: cfg_we with cfg_alto=4, cfg_bajo=2; push 4 words.
  - Required: almost_empty=1 at count 1..2, almost_full=1 at count 4.
  - Then cfg_alto=0 or cfg_alto=9 -> umbral_alto keeps 4.
  - Then cfg_bajo=5 with umbral_alto=4 -> umbral_bajo keeps 2.
- enb and async reset:
  - Stimulus: enb=0 with wr_en/rd_en/cfg_we toggling.
  - Required: count, data, thresholds and sticky flags unchanged.
  - Assert rst mid-cycle with count=5 -> count=0 and empty=1 before the next clk edge.
